// File: rtl/bist_pkg.sv
// Shared definitions for the BIST measurement blocks.
//   - FSM state encoding used by freq_meter
//   - nominal system clock frequency
package bist_pkg;

  // Nominal system clock frequency in Hz.
  localparam int unsigned CLK_HZ = 100_000_000;

  // Measurement FSM state encoding.
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ARM  = 2'd1;
  localparam logic [STATE_W-1:0] GATE = 2'd2;
  localparam logic [STATE_W-1:0] DONE = 2'd3;

endpackage : bist_pkg

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
// Ports:
//   clk    - sampling clock
//   rst    - asynchronous, active-high reset
//   din    - asynchronous input level
//   rise_c - combinational one-cycle pulse on each synchronised rising edge
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic hist;

  // Two-stage synchroniser followed by a one-cycle history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  // High for exactly one cycle when the synchronised level goes 0 -> 1.
  assign rise_c = sync & ~hist;

endmodule : sync_edge_detect

// File: rtl/freq_meter.sv
// Gated frequency / period meter for a slow asynchronous square wave.
// After start it waits for an anchor rising edge, then counts rising edges
// over GATE_CYCLES clk cycles, captures the first full period and reports a
// pass/fail verdict against [EXP_MIN, EXP_MAX].
// Ports:
//   clk        - system clock
//   rst        - asynchronous, active-high reset
//   sig_in     - asynchronous signal under test
//   start      - one-cycle request, honoured only when idle
//   busy       - measurement in progress (ARM, GATE and DONE cycles)
//   done       - one-cycle pulse when results update
//   freq_count - rising edges seen in the gate window (saturating)
//   period     - clk cycles between the anchor and the next edge
//                (all-ones when no edge follows the anchor in the window)
//   pass       - edge count within range and no timeout
//   timeout    - no anchor edge arrived within TIMEOUT_CYCLES
module freq_meter
  import bist_pkg::*;
#(
  parameter int unsigned GATE_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned CNT_W          = 27,
  parameter int unsigned PER_W          = 28,
  parameter int unsigned EXP_MIN        = 1,
  parameter int unsigned EXP_MAX        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq_count,
  output logic [PER_W-1:0] period,
  output logic             pass,
  output logic             timeout
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_MAX   = '1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;

  logic rise_c;

  logic [TMR_W-1:0]  timer,    timer_nxt;
  logic [GATE_W-1:0] gate_cnt, gate_nxt;
  logic [CNT_W-1:0]  edge_cnt, edge_nxt;
  logic [PER_W-1:0]  per_cnt,  per_nxt;
  logic [PER_W-1:0]  per_cap,  cap_nxt;
  logic              per_lock, lock_nxt;

  logic             busy_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] freq_nxt;
  logic [PER_W-1:0] period_nxt;
  logic             pass_nxt;
  logic             timeout_nxt;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (sig_in),
    .rise_c (rise_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. An edge in ARM wins over a simultaneous timer expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ARM;
        end
      end
      ARM: begin
        if (rise_c) begin
          state_next = GATE;
        end else if (timer == TMR_LAST) begin
          state_next = DONE;
        end
      end
      GATE: begin
        if (gate_cnt == GATE_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counter and result next values; results are loaded on entry to DONE so
  // they are already valid during the done pulse.
  always_comb begin
    timer_nxt   = timer;
    gate_nxt    = gate_cnt;
    edge_nxt    = edge_cnt;
    per_nxt     = per_cnt;
    cap_nxt     = per_cap;
    lock_nxt    = per_lock;
    freq_nxt    = freq_count;
    period_nxt  = period;
    pass_nxt    = pass;
    timeout_nxt = timeout;

    case (state)
      IDLE: begin
        if (start) begin
          timer_nxt   = '0;
          gate_nxt    = '0;
          edge_nxt    = '0;
          per_nxt     = '0;
          cap_nxt     = '0;
          lock_nxt    = 1'b0;
          timeout_nxt = 1'b0;
        end
      end

      ARM: begin
        timer_nxt = timer + TMR_W'(1);
        if (rise_c) begin
          // Anchor edge: not counted; period defaults to "longer than window".
          gate_nxt = '0;
          edge_nxt = '0;
          per_nxt  = '0;
          cap_nxt  = PER_MAX;
          lock_nxt = 1'b0;
        end else if (timer == TMR_LAST) begin
          timeout_nxt = 1'b1;
          freq_nxt    = '0;
          period_nxt  = '0;
          pass_nxt    = 1'b0;
        end
      end

      GATE: begin
        gate_nxt = gate_cnt + GATE_W'(1);

        if (rise_c && (edge_cnt != CNT_MAX)) begin
          edge_nxt = edge_cnt + CNT_W'(1);
        end

        // The first edge after the anchor closes the period measurement.
        if (!per_lock) begin
          if (rise_c) begin
            cap_nxt  = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + PER_W'(1);
            lock_nxt = 1'b1;
          end else if (per_cnt != PER_MAX) begin
            per_nxt = per_cnt + PER_W'(1);
          end
        end

        if (gate_cnt == GATE_LAST) begin
          freq_nxt   = edge_nxt;
          period_nxt = cap_nxt;
          pass_nxt   = (32'(edge_nxt) >= EXP_MIN) && (32'(edge_nxt) <= EXP_MAX);
        end
      end

      DONE: begin
      end
    endcase

    busy_nxt = (state_next != IDLE);
    done_nxt = (state_next == DONE);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      per_cnt  <= '0;
      per_cap  <= '0;
      per_lock <= 1'b0;
    end else begin
      timer    <= timer_nxt;
      gate_cnt <= gate_nxt;
      edge_cnt <= edge_nxt;
      per_cnt  <= per_nxt;
      per_cap  <= cap_nxt;
      per_lock <= lock_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      freq_count <= '0;
      period     <= '0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      done       <= done_nxt;
      freq_count <= freq_nxt;
      period     <= period_nxt;
      pass       <= pass_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule : freq_meter

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: directed and randomised sig_in
// waveforms described as lists of rising-edge times, checked against a
// reference computed directly from those edge times.
module tb_freq_meter;

  localparam int G    = 1000;
  localparam int TO   = 2000;
  localparam int EMIN = 9;
  localparam int EMAX = 11;
  localparam int PW   = 28;
  localparam int SYNC_LAT = 2;  // drive interval -> edge-visible interval

  logic clk = 1'b0;
  logic rst;
  logic sig_in;
  logic start;
  logic start_sat;

  logic          busy, done, pass, timeout;
  logic [26:0]   freq_count;
  logic [PW-1:0] period;

  logic          busy_s, done_s, pass_s, timeout_s;
  logic [3:0]    freq_s;
  logic [PW-1:0] period_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rises[$];
  int hi = 3;

  freq_meter #(
    .GATE_CYCLES(G), .TIMEOUT_CYCLES(TO), .CNT_W(27), .PER_W(PW),
    .EXP_MIN(EMIN), .EXP_MAX(EMAX)
  ) u_dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .freq_count(freq_count), .period(period),
    .pass(pass), .timeout(timeout)
  );

  freq_meter #(
    .GATE_CYCLES(G), .TIMEOUT_CYCLES(TO), .CNT_W(4), .PER_W(PW),
    .EXP_MIN(EMIN), .EXP_MAX(EMAX)
  ) u_sat (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_sat),
    .busy(busy_s), .done(done_s), .freq_count(freq_s), .period(period_s),
    .pass(pass_s), .timeout(timeout_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic level(input int n);
    foreach (rises[i]) begin
      if (n >= rises[i] && n < rises[i] + hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  // sig_in follows the rise list, updated just after each clock edge.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sig_in = level(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_wave();
    rises.delete();
    tick(10);
  endtask

  task automatic set_periodic(input int first, input int p, input int h);
    rises.delete();
    hi = h;
    for (int r = first; r < first + 4000; r += p) rises.push_back(r);
  endtask

  // Expected outcome of a start in interval t, from edge times alone.
  task automatic model(input int t, input int cw, output int e_done,
                       output longint e_freq, output longint e_per,
                       output logic e_pass, output logic e_to);
    int a;
    int cnt;
    int first;
    longint fmax;
    longint pmax;
    a = -1;
    cnt = 0;
    first = -1;
    fmax = (longint'(1) << cw) - 1;
    pmax = (longint'(1) << PW) - 1;
    foreach (rises[i]) begin
      if (a < 0 && rises[i] + SYNC_LAT >= t + 1 && rises[i] + SYNC_LAT <= t + TO)
        a = rises[i] + SYNC_LAT;
    end
    if (a < 0) begin
      e_to = 1'b1; e_done = t + 1 + TO; e_freq = 0; e_per = 0; e_pass = 1'b0;
    end else begin
      foreach (rises[i]) begin
        if (rises[i] + SYNC_LAT > a && rises[i] + SYNC_LAT <= a + G) begin
          cnt++;
          if (first < 0) first = rises[i] + SYNC_LAT;
        end
      end
      e_to   = 1'b0;
      e_done = a + G + 1;
      e_freq = (cnt > fmax) ? fmax : longint'(cnt);
      e_per  = (first < 0) ? pmax : (((first - a) > pmax) ? pmax : longint'(first - a));
      e_pass = (e_freq >= EMIN) && (e_freq <= EMAX);
    end
  endtask

  // One measurement: start after dly cycles, optional stray start at t+stray.
  task automatic measure(input string tag, input bit sat, input int dly, input int stray);
    int t;
    int e_done;
    int done_at;
    int n_done;
    longint e_freq;
    longint e_per;
    logic e_pass;
    logic e_to;
    logic [63:0] g_freq;
    logic [63:0] g_per;
    logic g_pass;
    logic g_to;
    tick(dly);
    t = cyc;
    if (sat) start_sat = 1'b1; else start = 1'b1;
    tick(1);
    start = 1'b0;
    start_sat = 1'b0;
    model(t, sat ? 4 : 27, e_done, e_freq, e_per, e_pass, e_to);
    @(negedge clk);
    check({tag, ":busy_on"}, 64'(sat ? busy_s : busy), 64'(1));
    n_done = 0; done_at = -1;
    g_freq = '0; g_per = '0; g_pass = 1'b0; g_to = 1'b0;
    while (cyc <= e_done + 3) begin
      @(posedge clk);
      #1;
      if (stray > 0 && cyc == t + stray) begin
        if (sat) start_sat = 1'b1; else start = 1'b1;
      end else begin
        start = 1'b0;
        start_sat = 1'b0;
      end
      @(negedge clk);
      if ((sat ? done_s : done) === 1'b1) begin
        n_done++;
        if (done_at < 0) begin
          done_at = cyc;
          g_freq  = sat ? 64'(freq_s) : 64'(freq_count);
          g_per   = sat ? 64'(period_s) : 64'(period);
          g_pass  = sat ? pass_s : pass;
          g_to    = sat ? timeout_s : timeout;
        end
      end
      if (cyc == e_done + 1) check({tag, ":busy_off"}, 64'(sat ? busy_s : busy), 64'(0));
    end
    start = 1'b0;
    start_sat = 1'b0;
    check({tag, ":done_cnt"}, 64'(n_done), 64'(1));
    check({tag, ":done_cyc"}, 64'(done_at), 64'(e_done));
    check({tag, ":freq"}, g_freq, 64'(e_freq));
    check({tag, ":period"}, g_per, 64'(e_per));
    check({tag, ":pass"}, 64'(g_pass), 64'(e_pass));
    check({tag, ":timeout"}, 64'(g_to), 64'(e_to));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":busy"}, 64'(busy), 64'(0));
    check({tag, ":done"}, 64'(done), 64'(0));
    check({tag, ":freq"}, 64'(freq_count), 64'(0));
    check({tag, ":period"}, 64'(period), 64'(0));
    check({tag, ":pass"}, 64'(pass), 64'(0));
    check({tag, ":timeout"}, 64'(timeout), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n;
    rst = 1'b1;
    start = 1'b0;
    start_sat = 1'b0;
    tick(3);
    @(negedge clk);
    check_zero("reset");
    tick(1);
    rst = 1'b0;
    tick(5);

    // Nominal 100-cycle square wave.
    clear_wave();
    set_periodic(cyc + 10, 100, 50);
    measure("nominal", 1'b0, 5, 0);

    // Stuck-low input times out.
    clear_wave();
    measure("stuck", 1'b0, 5, 0);

    // Only the anchor edge falls inside the window.
    clear_wave();
    set_periodic(cyc + 10, 3000, 1500);
    measure("single", 1'b0, 5, 0);

    // Edge on the last gate cycle is counted, one cycle later is not.
    clear_wave();
    hi = 3;
    r0 = cyc + 20;
    for (int k = 0; k < 10; k++) rises.push_back(r0 + 100 * k);
    rises.push_back(r0 + 1000);
    measure("edge_last_in", 1'b0, 5, 0);
    clear_wave();
    hi = 3;
    r0 = cyc + 20;
    for (int k = 0; k < 10; k++) rises.push_back(r0 + 100 * k);
    rises.push_back(r0 + 1001);
    measure("edge_last_out", 1'b0, 5, 0);

    // A start during GATE must not restart the measurement.
    clear_wave();
    set_periodic(cyc + 10, 100, 50);
    measure("stray_start", 1'b0, 5, 500);

    // 4-bit edge counter saturates.
    clear_wave();
    set_periodic(cyc + 10, 20, 10);
    measure("saturate", 1'b1, 5, 0);

    // Reset during GATE abandons the run.
    clear_wave();
    set_periodic(cyc + 10, 100, 50);
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(300);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    tick(3);
    rst = 1'b0;
    n = 0;
    repeat (1500) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("rst_mid:no_done", 64'(n), 64'(0));
    clear_wave();
    set_periodic(cyc + 10, 100, 50);
    measure("after_rst", 1'b0, 5, 0);

    // Randomised waveforms, start phases and stray starts.
    for (int k = 0; k < 8; k++) begin
      int p;
      int h;
      bit sat;
      int stray;
      p = int'($urandom_range(200, 4));
      h = int'($urandom_range(p - 2, 2));
      sat = bit'($urandom_range(1, 0));
      stray = ($urandom_range(1, 0) == 1) ? int'($urandom_range(900, 100)) : 0;
      clear_wave();
      set_periodic(cyc + int'($urandom_range(30, 5)), p, h);
      measure($sformatf("rnd%0d_p%0d", k, p), sat, int'($urandom_range(p, 1)), stray);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_freq_meter
